cam_stream_arbiter: RTL and testbench
=====================================

# cam_stream_arbiter

Packet-level round-robin arbiter that lets NUM_REQ host streams share one CAM kernel. It sits in front of the CAM kernel's p0 input stream and behind its p1 result stream. Whole command packets (header plus payload) are forwarded without interleaving. A tag FIFO records which requester issued each SEARCH, so that result beats can be steered back to that requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- C_DATA_WIDTH, 512, stream beat width
- OP_CODE_WIDTH, 3, opcode field width in header bits [OP_CODE_WIDTH-1:0]
- TAG_DEPTH, 16, outstanding-SEARCH tag FIFO depth (power of 2)
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- s_TDATA  in  NUM_REQ*C_DATA_WIDTH  requester beats; requester i occupies slice i
- s_TVALID  in  NUM_REQ  per-requester valid
- s_TREADY  out  NUM_REQ  per-requester ready
- m_TDATA  out  C_DATA_WIDTH  to CAM p0
- m_TVALID  out  1  to CAM p0
- m_TREADY  in  1  from CAM p0
- r_TDATA  in  C_DATA_WIDTH  from CAM p1
- r_TVALID  in  1  from CAM p1
- r_TREADY  out  1  to CAM p1
- o_TDATA  out  C_DATA_WIDTH  result data, shared by all requesters
- o_TVALID  out  NUM_REQ  per-requester result valid
- o_TREADY  in  NUM_REQ  per-requester result ready
- grant_id  out  $clog2(NUM_REQ)  requester currently owning m_*
- busy  out  1  1 while a packet is in flight or tags are outstanding
- err_orphan  out  1  sticky; set when r_TVALID=1 while the tag FIFO is empty

## Operation
- **Packet format.** The header is the first beat.
  - opcode = bits[OP_CODE_WIDTH-1:0]: IDLE=0, UPDATE_ALL=1, SEARCH=2, UPDATE_ONE=3.
  - LEN = bits[61:32], unsigned 30-bit; it counts the payload beats that follow the header.
  - Packet length is 1+LEN beats.
- **FSM states:** ARB, XFER.
- **ARB state.**
  - Eligible requester: s_TVALID[i]=1, and, if its header opcode is SEARCH with LEN≠0, the tag FIFO is not full.
  - Search order starts at rr_ptr and wraps modulo NUM_REQ.
  - On the first eligible requester: register grant_id, load beat counter = LEN, go to XFER.
  - If no requester is eligible, stay in ARB.
  - All s_TREADY=0 and m_TVALID=0 while in ARB.
- **XFER state.**
  - m_TDATA = s_TDATA[grant_id], m_TVALID = s_TVALID[grant_id], s_TREADY[grant_id] = m_TREADY. All other s_TREADY=0.
  - Header handshake: if opcode is SEARCH and LEN≠0, push {grant_id, LEN} into the tag FIFO.
  - Each payload handshake decrements the counter.
  - Last beat is the header when LEN=0, otherwise the handshake with counter=1. On the last beat: rr_ptr ← grant_id+1 (mod NUM_REQ), go to ARB.
- **Response path.**
  - If the tag FIFO is non-empty, with head {id, n}: o_TDATA = r_TDATA, o_TVALID[id] = r_TVALID, r_TREADY = o_TREADY[id]. All other o_TVALID=0.
  - Each handshake decrements a response counter loaded from n. The tag is popped on the n-th beat, and the next tag becomes active the following cycle.
  - If the tag FIFO is empty: r_TREADY=0, all o_TVALID=0. If r_TVALID=1 in this condition, set err_orphan.
- **busy** = (state==XFER) | tag FIFO non-empty.
- **Reset (asserted any time, including mid-packet).**
  - State → ARB, rr_ptr=0, grant_id=0, counters=0, tag FIFO emptied, err_orphan=0.
  - All TREADY/TVALID outputs are 0 while reset is asserted.
  - In-flight packets are abandoned. Requesters must restart them.

## Timing
- Request path is combinational in XFER: zero added latency and full throughput of one beat per cycle.
- ARB costs exactly one bubble cycle per packet: the earliest header handshake is the cycle after the grant edge.
- Back-to-back packets from any requesters: throughput is (1+LEN)/(2+LEN).
- Tag push and pop in the same cycle: FIFO occupancy is unchanged. A push when full cannot occur because of the eligibility rule.
- A tag pushed in cycle t is visible at the response head no earlier than t+1.
- Response path is combinational: zero added latency, one beat per cycle, including across tag boundaries after a one-cycle head update.
- Outputs out of reset: s_TREADY=0, m_TVALID=0, r_TREADY=0, o_TVALID=0, grant_id=0, busy=0, err_orphan=0.

## Test plan
- **Single SEARCH.** Req0 sends a SEARCH header with LEN=3, then 3 beats; the CAM returns 3 beats.
  - m_* carries 4 beats unchanged.
  - Tag {0,3} is pushed, then popped after the third o_TVALID[0] beat.
  - busy drops the cycle after the pop.
- **Round robin.** All 4 requesters hold UPDATE_ONE packets with LEN=1.
  - Grant order is 0,1,2,3,0.
  - Each packet is 2 beats followed by a 1-cycle bubble.
  - No beats from different packets interleave.
- **Tag full.** TAG_DEPTH=2; req1 issues 3 SEARCH LEN=1 packets and r_TVALID is held low.
  - The third header stalls in ARB while req2's UPDATE_ALL packet is granted.
  - After one result beat, req1's third packet is granted.
- **Back-pressure.** m_TREADY toggles 1010… during a LEN=5 packet, and o_TREADY[2]=0 for 4 cycles during a response.
  - No beat is lost or duplicated.
  - s_TREADY and r_TREADY mirror their respective ready inputs.
- **Orphan and LEN=0.**
  - SEARCH with LEN=0 forwards 1 beat and pushes no tag.
  - A spurious r_TVALID with an empty tag FIFO sets err_orphan, which holds until reset.
- **Reset mid-packet.** Assert ap_rst_n=0 asynchronously on the 2nd payload beat of req3's LEN=4 packet.
  - All outputs go to reset values immediately.
  - After release, req0's pending packet is granted first (rr_ptr=0).

Source files
------------

// File: rtl/cam_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one CAM kernel between NUM_REQ host streams.
// A tag FIFO remembers who issued each SEARCH so result beats are steered back.
module cam_stream_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned C_DATA_WIDTH  = 512,
  parameter int unsigned OP_CODE_WIDTH = 3,
  parameter int unsigned TAG_DEPTH     = 16
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]   s_TDATA,
  input  logic [NUM_REQ-1:0]                s_TVALID,
  output logic [NUM_REQ-1:0]                s_TREADY,
  output logic [C_DATA_WIDTH-1:0]           m_TDATA,
  output logic                              m_TVALID,
  input  logic                              m_TREADY,
  input  logic [C_DATA_WIDTH-1:0]           r_TDATA,
  input  logic                              r_TVALID,
  output logic                              r_TREADY,
  output logic [C_DATA_WIDTH-1:0]           o_TDATA,
  output logic [NUM_REQ-1:0]                o_TVALID,
  input  logic [NUM_REQ-1:0]                o_TREADY,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy,
  output logic                              err_orphan
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned LEN_W = 30;
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned TAG_W = ID_W + LEN_W;
  localparam logic [OP_CODE_WIDTH-1:0] OP_SEARCH = OP_CODE_WIDTH'(2);

  typedef enum logic {ARB, XFER} state_t;

  state_t                  state, state_nxt;
  logic [ID_W-1:0]         rr_ptr, rr_nxt, pick;
  logic                    found;
  logic [LEN_W-1:0]        beat_cnt;
  logic                    hdr_phase;
  logic [C_DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic [LEN_W-1:0]        req_len  [NUM_REQ];
  logic [NUM_REQ-1:0]      eligible;
  logic [C_DATA_WIDTH-1:0] gdata;
  logic [LEN_W-1:0]        glen;
  logic                    hs_m, last_beat, push;

  logic [TAG_W-1:0]        tag_mem [TAG_DEPTH];
  logic [PTR_W:0]          wr_ptr, rd_ptr;
  logic                    tag_empty, tag_full;
  logic [TAG_W-1:0]        head;
  logic [ID_W-1:0]         head_id;
  logic [LEN_W-1:0]        head_len, rsp_cnt;
  logic                    hs_r, pop;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data[g] = s_TDATA[g*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign req_len[g]  = req_data[g][61:32];
  end

  assign tag_empty = (wr_ptr == rd_ptr);
  assign tag_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A non-empty SEARCH needs a free tag slot before it may be granted.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = s_TVALID[i] &&
                    !((req_data[i][OP_CODE_WIDTH-1:0] == OP_SEARCH) &&
                      (req_len[i] != '0) && tag_full);
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign gdata     = req_data[grant_id];
  assign glen      = gdata[61:32];
  assign hs_m      = (state == XFER) && s_TVALID[grant_id] && m_TREADY;
  assign last_beat = hs_m && (hdr_phase ? (glen == '0) : (beat_cnt == LEN_W'(1)));
  assign push      = hs_m && hdr_phase && (gdata[OP_CODE_WIDTH-1:0] == OP_SEARCH) &&
                     (glen != '0);
  assign rr_nxt    = (32'(grant_id) + 32'd1 >= NUM_REQ) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ARB;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_TREADY  = '0;
    m_TVALID  = 1'b0;
    m_TDATA   = gdata;
    case (state)
      ARB:  if (found) state_nxt = XFER;
      XFER: begin
        m_TVALID           = s_TVALID[grant_id];
        s_TREADY[grant_id] = m_TREADY;
        if (last_beat) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  // Grant bookkeeping: beat counter tracks remaining payload after the header.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      beat_cnt  <= '0;
      hdr_phase <= 1'b0;
    end else if ((state == ARB) && found) begin
      grant_id  <= pick;
      beat_cnt  <= req_len[pick];
      hdr_phase <= 1'b1;
    end else if (hs_m) begin
      hdr_phase <= 1'b0;
      if (!hdr_phase) beat_cnt <= beat_cnt - LEN_W'(1);
      if (last_beat)  rr_ptr   <= rr_nxt;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) tag_mem[wr_ptr[PTR_W-1:0]] <= {grant_id, glen};
  end

  assign head     = tag_mem[rd_ptr[PTR_W-1:0]];
  assign head_id  = head[TAG_W-1:LEN_W];
  assign head_len = head[LEN_W-1:0];
  assign o_TDATA  = r_TDATA;
  assign hs_r     = !tag_empty && r_TVALID && o_TREADY[head_id];
  assign pop      = hs_r && (rsp_cnt + LEN_W'(1) == head_len);
  assign busy     = (state == XFER) || !tag_empty;

  always_comb begin
    r_TREADY = 1'b0;
    o_TVALID = '0;
    if (!tag_empty) begin
      o_TVALID[head_id] = r_TVALID;
      r_TREADY          = o_TREADY[head_id];
    end
  end

  // Tag pointers and per-tag response beat count.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rsp_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
        rsp_cnt <= '0;
      end else if (hs_r) begin
        rsp_cnt <= rsp_cnt + LEN_W'(1);
      end
      if (tag_empty && r_TVALID) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_stream_arbiter.sv
// Directed bench for cam_stream_arbiter: 4 requesters, 64-bit beats, 2-entry tag FIFO.
module tb_cam_stream_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 64;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [NR*DW-1:0]  s_TDATA;
  logic [NR-1:0]     s_TVALID;
  logic [NR-1:0]     s_TREADY;
  logic [DW-1:0]     m_TDATA;
  logic              m_TVALID;
  logic              m_TREADY;
  logic [DW-1:0]     r_TDATA;
  logic              r_TVALID;
  logic              r_TREADY;
  logic [DW-1:0]     o_TDATA;
  logic [NR-1:0]     o_TVALID;
  logic [NR-1:0]     o_TREADY;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err_orphan;

  int n_checks = 0;
  int n_pass   = 0;

  cam_stream_arbiter #(
    .NUM_REQ(NR), .C_DATA_WIDTH(DW), .OP_CODE_WIDTH(3), .TAG_DEPTH(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_TDATA(s_TDATA), .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
    .m_TDATA(m_TDATA), .m_TVALID(m_TVALID), .m_TREADY(m_TREADY),
    .r_TDATA(r_TDATA), .r_TVALID(r_TVALID), .r_TREADY(r_TREADY),
    .o_TDATA(o_TDATA), .o_TVALID(o_TVALID), .o_TREADY(o_TREADY),
    .grant_id(grant_id), .busy(busy), .err_orphan(err_orphan)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] hdr(input int op, input int len, input int id);
    logic [63:0] h;
    h = '0;
    h[2:0]   = 3'(op);
    h[15:8]  = 8'(id);
    h[61:32] = 30'(len);
    return h;
  endfunction

  function automatic logic [63:0] pay(input int id, input int b);
    return 64'hD000_0000 + 64'(id * 16 + b);
  endfunction

  task automatic set_req(input int i, input logic v, input logic [63:0] d);
    s_TVALID[i]         = v;
    s_TDATA[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    s_TVALID = '0;
    s_TDATA  = '0;
    r_TVALID = 1'b0;
    r_TDATA  = '0;
    o_TREADY = '0;
    m_TREADY = 1'b1;
    step();
    step();
    ap_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int b, k, cyc, g;

    // Reset values, with requesters already asserting valid
    do_reset();
    ap_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, hdr(3, 1, i));
    step();
    #1;
    check("rst_s_tready", 64'(s_TREADY), 64'h0);
    check("rst_m_tvalid", 64'(m_TVALID), 64'h0);
    check("rst_r_tready", 64'(r_TREADY), 64'h0);
    check("rst_o_tvalid", 64'(o_TVALID), 64'h0);
    check("rst_grant",    64'(grant_id), 64'h0);
    check("rst_busy",     64'(busy),     64'h0);
    check("rst_orphan",   64'(err_orphan), 64'h0);

    // Single SEARCH LEN=3 from req0
    do_reset();
    set_req(0, 1'b1, hdr(2, 3, 0));
    #1; check("t1_bubble", 64'(m_TVALID), 64'h0);
    step();
    #1;
    check("t1_grant",  64'(grant_id), 64'h0);
    check("t1_mvalid", 64'(m_TVALID), 64'h1);
    check("t1_hdr",    m_TDATA, hdr(2, 3, 0));
    check("t1_sready", 64'(s_TREADY), 64'h1);
    step();
    for (int p = 1; p <= 3; p++) begin
      set_req(0, 1'b1, pay(0, p));
      #1; check("t1_payload", m_TDATA, pay(0, p));
      step();
    end
    set_req(0, 1'b0, '0);
    #1;
    check("t1_arb_after", 64'(m_TVALID), 64'h0);
    check("t1_busy_tag",  64'(busy), 64'h1);
    o_TREADY = 4'hF;
    for (int p = 0; p < 3; p++) begin
      r_TVALID = 1'b1;
      r_TDATA  = 64'hAAAA_0000 + 64'(p);
      #1;
      check("t1_o_tvalid", 64'(o_TVALID), 64'h1);
      check("t1_o_tdata",  o_TDATA, 64'hAAAA_0000 + 64'(p));
      check("t1_r_tready", 64'(r_TREADY), 64'h1);
      step();
    end
    r_TVALID = 1'b0;
    #1;
    check("t1_busy_drop", 64'(busy), 64'h0);
    check("t1_o_idle",    64'(o_TVALID), 64'h0);

    // Round robin across four UPDATE_ONE LEN=1 packets
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, hdr(3, 1, i));
    for (int p = 0; p < 5; p++) begin
      g = order[p];
      #1; check("t2_bubble", 64'(m_TVALID), 64'h0);
      step();
      #1;
      check("t2_grant",  64'(grant_id), 64'(g));
      check("t2_hdr",    m_TDATA, hdr(3, 1, g));
      check("t2_sready", 64'(s_TREADY), 64'(1 << g));
      step();
      set_req(g, 1'b1, pay(g, 1));
      #1;
      check("t2_payload", m_TDATA, pay(g, 1));
      check("t2_sready2", 64'(s_TREADY), 64'(1 << g));
      step();
      set_req(g, 1'b1, hdr(3, 1, g));
    end

    // Tag FIFO full stalls a third SEARCH while another requester proceeds
    do_reset();
    for (int p = 0; p < 2; p++) begin
      set_req(1, 1'b1, hdr(2, 1, 1));
      #1; check("t3_bubble", 64'(m_TVALID), 64'h0);
      step();
      #1; check("t3_grant", 64'(grant_id), 64'h1);
      step();
      set_req(1, 1'b1, pay(1, 1));
      #1; check("t3_payload", m_TDATA, pay(1, 1));
      step();
    end
    set_req(1, 1'b1, hdr(2, 1, 1));
    for (int p = 0; p < 2; p++) begin
      #1;
      check("t3_stall_mvalid", 64'(m_TVALID), 64'h0);
      check("t3_stall_sready", 64'(s_TREADY), 64'h0);
      step();
    end
    set_req(2, 1'b1, hdr(1, 0, 2));
    #1; check("t3_req2_bubble", 64'(m_TVALID), 64'h0);
    step();
    #1;
    check("t3_req2_grant", 64'(grant_id), 64'h2);
    check("t3_req2_hdr",   m_TDATA, hdr(1, 0, 2));
    step();
    set_req(2, 1'b0, '0);
    #1;
    check("t3_still_stall", 64'(m_TVALID), 64'h0);
    check("t3_busy",        64'(busy), 64'h1);
    o_TREADY = 4'b0010;
    r_TVALID = 1'b1;
    r_TDATA  = 64'hCC01;
    #1;
    check("t3_o_tvalid", 64'(o_TVALID), 64'h2);
    check("t3_r_tready", 64'(r_TREADY), 64'h1);
    step();
    r_TVALID = 1'b0;
    #1; check("t3_grant_bubble", 64'(m_TVALID), 64'h0);
    step();
    #1;
    check("t3_req1_grant", 64'(grant_id), 64'h1);
    check("t3_req1_hdr",   m_TDATA, hdr(2, 1, 1));

    // Back-pressure on both paths, SEARCH LEN=5 from req2
    do_reset();
    set_req(2, 1'b1, hdr(2, 5, 2));
    #1; check("t4_bubble", 64'(m_TVALID), 64'h0);
    step();
    b = 0;
    cyc = 0;
    while (b < 6 && cyc < 20) begin
      m_TREADY = (cyc % 2 == 0);
      set_req(2, 1'b1, (b == 0) ? hdr(2, 5, 2) : pay(2, b));
      #1;
      check("t4_mvalid", 64'(m_TVALID), 64'h1);
      check("t4_mdata",  m_TDATA, (b == 0) ? hdr(2, 5, 2) : pay(2, b));
      check("t4_sready_mirror", 64'(s_TREADY), 64'(m_TREADY) << 2);
      step();
      if (m_TREADY) b++;
      cyc++;
    end
    set_req(2, 1'b0, '0);
    m_TREADY = 1'b1;
    #1;
    check("t4_pkt_done", 64'(m_TVALID), 64'h0);
    check("t4_busy",     64'(busy), 64'h1);
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 20) begin
      o_TREADY = (cyc >= 1 && cyc <= 4) ? 4'b0000 : 4'b0100;
      r_TVALID = 1'b1;
      r_TDATA  = 64'hBB00 + 64'(k);
      #1;
      check("t4_o_tvalid", 64'(o_TVALID), 64'h4);
      check("t4_o_tdata",  o_TDATA, 64'hBB00 + 64'(k));
      check("t4_rready_mirror", 64'(r_TREADY), 64'(o_TREADY[2]));
      step();
      if (o_TREADY[2]) k++;
      cyc++;
    end
    r_TVALID = 1'b0;
    #1; check("t4_idle", 64'(busy), 64'h0);

    // SEARCH LEN=0 pushes no tag; spurious result sets sticky orphan flag
    do_reset();
    set_req(3, 1'b1, hdr(2, 0, 3));
    #1; check("t5_bubble", 64'(m_TVALID), 64'h0);
    step();
    #1;
    check("t5_grant",  64'(grant_id), 64'h3);
    check("t5_hdr",    m_TDATA, hdr(2, 0, 3));
    check("t5_sready", 64'(s_TREADY), 64'h8);
    step();
    set_req(3, 1'b0, '0);
    #1;
    check("t5_single_beat", 64'(m_TVALID), 64'h0);
    check("t5_no_tag",      64'(busy), 64'h0);
    check("t5_orphan_clr",  64'(err_orphan), 64'h0);
    o_TREADY = 4'hF;
    r_TVALID = 1'b1;
    #1;
    check("t5_r_tready", 64'(r_TREADY), 64'h0);
    check("t5_o_tvalid", 64'(o_TVALID), 64'h0);
    step();
    r_TVALID = 1'b0;
    #1; check("t5_orphan_set", 64'(err_orphan), 64'h1);
    step(); step(); step();
    #1; check("t5_orphan_hold", 64'(err_orphan), 64'h1);

    // Reset mid-packet: rr_ptr must return to 0
    do_reset();
    #1; check("t6_orphan_rst", 64'(err_orphan), 64'h0);
    set_req(1, 1'b1, hdr(3, 0, 1));
    step();
    #1; check("t6_req1_grant", 64'(grant_id), 64'h1);
    step();
    set_req(1, 1'b0, '0);
    set_req(3, 1'b1, hdr(3, 4, 3));
    #1; check("t6_bubble", 64'(m_TVALID), 64'h0);
    step();
    #1; check("t6_req3_grant", 64'(grant_id), 64'h3);
    step();
    set_req(3, 1'b1, pay(3, 1));
    step();
    set_req(3, 1'b1, pay(3, 2));
    set_req(0, 1'b1, hdr(3, 0, 0));
    #1; check("t6_payload2", m_TDATA, pay(3, 2));
    ap_rst_n = 1'b0;
    #1;
    check("t6_rst_mvalid", 64'(m_TVALID), 64'h0);
    check("t6_rst_sready", 64'(s_TREADY), 64'h0);
    check("t6_rst_grant",  64'(grant_id), 64'h0);
    check("t6_rst_busy",   64'(busy), 64'h0);
    step();
    ap_rst_n = 1'b1;
    set_req(3, 1'b1, hdr(3, 4, 3));
    #1; check("t6_post_bubble", 64'(m_TVALID), 64'h0);
    step();
    #1;
    check("t6_post_grant", 64'(grant_id), 64'h0);
    check("t6_post_hdr",   m_TDATA, hdr(3, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
